rf_2p_bank: RTL
===============

# rf_2p_bank

Parametrised, behavioural two-port register file built from flops, with NBANK independent banks of wordWd words each. It is the technology-independent successor to the fixed-size 2-port RF macro wrapper. It adds a registered read-valid strobe, optional write-to-read bypass, per-word written flags, a bulk clear, and error flagging for out-of-range or unwritten reads. Processing-element kernel and partial-sum buffers use it wherever no hard macro size fits.

## Interface
Parameters:
- wordWd, 12, words per bank (any value ≥ 2; not restricted to macro sizes)
- DWd, 32, data width in bits
- NBANK, 2, number of banks (≥ 1)
- BYPASS, 1, 1 = same-cycle write forwarded to read of same location; 0 = read returns old data
- AWd, $clog2(wordWd), word address width
- BWd, (NBANK>1 ? $clog2(NBANK) : 1), bank select width

Ports:
- i_clk  input  1  clock, all state on rising edge
- i_rstn  input  1  asynchronous active-low reset
- i_read  input  1  read request, active high
- i_rbank  input  BWd  read bank
- i_raddr  input  AWd  read word address
- i_write  input  1  write request, active high
- i_wbank  input  BWd  write bank
- i_waddr  input  AWd  write word address
- i_wdata  input  DWd  write data
- i_clr  input  1  synchronous clear of all written flags
- o_rdata  output  DWd  registered read data
- o_rvalid  output  1  one-cycle strobe: o_rdata updated
- o_rerr  output  1  read result invalid (out of range or unwritten); valid with o_rvalid

## Operation
- Storage: NBANK×wordWd×DWd flops, not reset. Per-word written flag wv[b][a] is reset to 0.
- Location is in range iff bank < NBANK and addr < wordWd.
- Write (i_write=1, in range): mem[wbank][waddr] ← i_wdata; wv ← 1. An out-of-range write is dropped silently and changes no state.
- Read (i_read=1):
  - in range and wv=1: o_rdata ← mem, o_rerr ← 0
  - in range and wv=0: o_rdata ← 0, o_rerr ← 1
  - out of range: o_rdata ← 0, o_rerr ← 1
  - o_rvalid ← 1 in all three cases
- No read: o_rvalid ← 0; o_rdata and o_rerr hold their last values.
- Simultaneous read and write to the same in-range location:
  - BYPASS=1: o_rdata ← i_wdata, o_rerr ← 0, even if the word was unwritten.
  - BYPASS=0: the read returns the pre-write content and pre-write flag state.
  - Different locations: fully independent, no stall.
- i_clr=1: all wv ← 0 at the edge. A write in the same cycle wins for its own word (flag ends 1). A read in the same cycle sees the pre-clear flags; the bypass rule still applies.
- Reset (i_rstn=0, asynchronous): o_rdata=0, o_rvalid=0, o_rerr=0, all wv=0. Reset mid-operation discards any in-flight read; o_rvalid stays 0 after release until a new read.

## Timing
- Read latency: 1 cycle. A request sampled at edge N produces o_rdata, o_rvalid and o_rerr after edge N, valid during cycle N+1.
- Throughput: one read plus one write per cycle, sustained, with no back-pressure.
- Write visibility: a write at edge N is readable by a request sampled at edge N+1; also at edge N when BYPASS=1.
- i_clr takes effect at the sampling edge. A read sampled at the next edge sees the cleared flags.
- All outputs are driven directly from flops; there is no combinational input-to-output path.

## Test plan
- Reset, then read bank0/addr3 → o_rvalid=1, o_rerr=1, o_rdata=0 one cycle later.
- Write 0xDEADBEEF to bank1/addr11, then read bank1/addr11 next cycle → o_rdata=0xDEADBEEF, o_rerr=0; bank0/addr11 still reads o_rerr=1.
- Same-cycle write 0x12345678 and read of bank0/addr5 (old 0xAAAA5555):
  - BYPASS=1 → 0x12345678
  - BYPASS=0 → 0xAAAA5555
- Write addr 12 with wordWd=12, then read addr 12 → o_rerr=1, o_rdata=0; addresses 0–11 are unchanged.
- Fill all words, pulse i_clr together with a write of 0x1 to bank0/addr0:
  - every word except bank0/addr0 reads o_rerr=1
  - bank0/addr0 reads 0x1
- Back-to-back reads on 8 consecutive cycles → o_rvalid high for 8 cycles, with correct data each cycle. Assert i_rstn=0 mid-stream → all outputs 0 immediately, and flags are cleared.

Source files
------------

// File: rtl/rf_2p_bank_if.sv
// rtl/rf_2p_bank_if.sv - read/write/clear request bundle for the two-port banked register file
interface rf_2p_bank_if #(
    parameter int DWd = 32,
    parameter int AWd = 4,
    parameter int BWd = 1
);
    logic           i_read;
    logic [BWd-1:0] i_rbank;
    logic [AWd-1:0] i_raddr;
    logic           i_write;
    logic [BWd-1:0] i_wbank;
    logic [AWd-1:0] i_waddr;
    logic [DWd-1:0] i_wdata;
    logic           i_clr;
    logic [DWd-1:0] o_rdata;
    logic           o_rvalid;
    logic           o_rerr;

    modport master (
        output i_read, i_rbank, i_raddr,
        output i_write, i_wbank, i_waddr, i_wdata,
        output i_clr,
        input  o_rdata, o_rvalid, o_rerr
    );

    modport slave (
        input  i_read, i_rbank, i_raddr,
        input  i_write, i_wbank, i_waddr, i_wdata,
        input  i_clr,
        output o_rdata, o_rvalid, o_rerr
    );
endinterface

// File: rtl/rf_2p_bank.sv
// rtl/rf_2p_bank.sv - flop-based banked two-port register file with written flags, bypass and read error
module rf_2p_bank #(
    parameter int wordWd = 12,
    parameter int DWd    = 32,
    parameter int NBANK  = 2,
    parameter int BYPASS = 1,
    parameter int AWd    = $clog2(wordWd),
    parameter int BWd    = (NBANK > 1 ? $clog2(NBANK) : 1)
) (
    input logic        i_clk,
    input logic        i_rstn,
    rf_2p_bank_if.slave rf
);
    // One extra bit so the bound itself is representable even when it is a power of two.
    localparam logic [AWd:0] NWORD_L = (AWd+1)'(wordWd);
    localparam logic [BWd:0] NBANK_L = (BWd+1)'(NBANK);

    logic [DWd-1:0] mem [NBANK][wordWd];
    logic           wv  [NBANK][wordWd];

    logic           wr_in;
    logic           rd_in;
    logic           same_loc;
    logic [DWd-1:0] rd_data_n;
    logic           rd_err_n;
    logic [DWd-1:0] rdata_q;
    logic           rvalid_q;
    logic           rerr_q;

    assign wr_in    = ({1'b0, rf.i_waddr} < NWORD_L) && ({1'b0, rf.i_wbank} < NBANK_L);
    assign rd_in    = ({1'b0, rf.i_raddr} < NWORD_L) && ({1'b0, rf.i_rbank} < NBANK_L);
    assign same_loc = rf.i_write && wr_in && (rf.i_wbank == rf.i_rbank) && (rf.i_waddr == rf.i_raddr);

    // Data array: no reset, only in-range writes land.
    always_ff @(posedge i_clk) begin
        if (rf.i_write && wr_in) begin
            mem[rf.i_wbank][rf.i_waddr] <= rf.i_wdata;
        end
    end

    // Written flags: clear drops everything, a same-cycle write re-marks its own word.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int a = 0; a < wordWd; a++) begin
                    wv[b][a] <= 1'b0;
                end
            end
        end else begin
            if (rf.i_clr) begin
                for (int b = 0; b < NBANK; b++) begin
                    for (int a = 0; a < wordWd; a++) begin
                        wv[b][a] <= 1'b0;
                    end
                end
            end
            if (rf.i_write && wr_in) begin
                wv[rf.i_wbank][rf.i_waddr] <= 1'b1;
            end
        end
    end

    // Read result selection from pre-edge state, with optional forwarding of the concurrent write.
    always_comb begin
        rd_data_n = '0;
        rd_err_n  = 1'b1;
        if (rd_in) begin
            if ((BYPASS != 0) && same_loc) begin
                rd_data_n = rf.i_wdata;
                rd_err_n  = 1'b0;
            end else if (wv[rf.i_rbank][rf.i_raddr]) begin
                rd_data_n = mem[rf.i_rbank][rf.i_raddr];
                rd_err_n  = 1'b0;
            end
        end
    end

    // Output registers: strobe every read, hold data and error between reads.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            rvalid_q <= rf.i_read;
            if (rf.i_read) begin
                rdata_q <= rd_data_n;
                rerr_q  <= rd_err_n;
            end
        end
    end

    assign rf.o_rdata  = rdata_q;
    assign rf.o_rvalid = rvalid_q;
    assign rf.o_rerr   = rerr_q;
endmodule
